// File: rtl/dlx_decode.sv
// dlx_decode: decode/operand-fetch stage of the DLX pipeline.
// Latches one instruction from fetch and decodes its source and destination
// fields. It drives the register-file read ports, stalls on RAW/WAW hazards
// against a 32-entry in-flight scoreboard, forwards same-cycle writeback data,
// and presents the decoded operand bundle to execute with valid/ready.
module dlx_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  Rs1,
  output logic [4:0]  Rs2,
  input  logic [31:0] S1,
  input  logic [31:0] S2,
  input  logic        wb_enable,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_opcode,
  output logic [10:0] out_func,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic [31:0] out_pc
);

  typedef enum logic [1:0] {IDLE, CHECK, CAPT, VALID} state_t;

  state_t      state, state_nx;
  logic [31:0] ir, pc_q;
  logic [31:0] busy, busy_nx;
  logic        fwd1, fwd2;
  logic [31:0] fwd_data;

  logic [5:0]  opcode;
  logic        use1, use2;
  logic [4:0]  dest;
  logic [31:0] imm;
  logic [31:0] clr_mask, eff_busy;
  logic        hazard;

  // Field decode of the latched instruction word.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    opcode = ir[31:26];
    use1   = 1'b1;
    use2   = 1'b0;
    dest   = ir[20:16];
    case (opcode)
      6'h00:               begin use2 = 1'b1; dest = ir[15:11]; end
      6'h28, 6'h29, 6'h2B: begin use2 = 1'b1; dest = 5'd0;      end
      6'h04, 6'h05, 6'h12: dest = 5'd0;
      6'h02:               begin use1 = 1'b0; dest = 5'd0;      end
      6'h03:               begin use1 = 1'b0; dest = 5'd31;     end
      6'h13:               dest = 5'd31;
      default:             ;
    endcase
    if (opcode == 6'h02 || opcode == 6'h03)
      imm = {{6{ir[25]}}, ir[25:0]};
    else
      imm = {{16{ir[15]}}, ir[15:0]};
  end

  // Unused sources read r0, so they can never hit a busy bit or forward.
  assign Rs1 = use1 ? ir[25:21] : 5'd0;
  assign Rs2 = use2 ? ir[20:16] : 5'd0;

  // A writeback landing this cycle no longer blocks; busy[0] is always 0.
  assign clr_mask = (wb_enable && wb_rd != 5'd0) ? (32'd1 << wb_rd) : 32'd0;
  assign eff_busy = busy & ~clr_mask;
  assign hazard   = eff_busy[Rs1] | eff_busy[Rs2] | eff_busy[dest];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == VALID);

  // Next-state and scoreboard update; a same-cycle set beats the clear.
  always_comb begin
    state_nx = state;
    busy_nx  = busy & ~clr_mask;
    case (state)
      IDLE:  if (in_valid) state_nx = CHECK;
      CHECK: if (!hazard) begin
        state_nx = CAPT;
        if (dest != 5'd0) busy_nx[dest] = 1'b1;
      end
      CAPT:  state_nx = VALID;
      VALID: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx[0] = 1'b0;
  end

  // State, scoreboard, latched instruction and forwarding capture.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= '0;
      ir       <= '0;
      pc_q     <= '0;
      fwd1     <= 1'b0;
      fwd2     <= 1'b0;
      fwd_data <= '0;
    end else begin
      state <= state_nx;
      busy  <= busy_nx;
      if (state == IDLE && in_valid) begin
        ir   <= in_instr;
        pc_q <= in_pc;
      end
      if (state == CHECK && !hazard) begin
        fwd1     <= wb_enable && (wb_rd == Rs1) && (Rs1 != 5'd0);
        fwd2     <= wb_enable && (wb_rd == Rs2) && (Rs2 != 5'd0);
        fwd_data <= wb_data;
      end
    end
  end

  // Operand bundle, registered in CAPT and held stable through VALID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_opcode <= '0;
      out_func   <= '0;
      out_a      <= '0;
      out_b      <= '0;
      out_imm    <= '0;
      out_rd     <= '0;
      out_pc     <= '0;
    end else if (state == CAPT) begin
      out_opcode <= opcode;
      out_func   <= (opcode == 6'h00) ? ir[10:0] : 11'd0;
      out_a      <= fwd1 ? fwd_data : S1;
      out_b      <= fwd2 ? fwd_data : S2;
      out_imm    <= imm;
      out_rd     <= dest;
      out_pc     <= pc_q;
    end
  end

endmodule

// File: tb/tb_dlx_decode.sv
// Self-checking bench for dlx_decode: directed scenarios followed by random
// instructions checked against a transaction-level reference model
// (architectural register values plus a set of in-flight destinations).
module tb_dlx_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  Rs1, Rs2;
  logic [31:0] S1, S2;
  logic        wb_enable;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [5:0]  out_opcode;
  logic [10:0] out_func;
  logic [31:0] out_a, out_b, out_imm, out_pc;
  logic [4:0]  out_rd;

  dlx_decode dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .Rs1(Rs1), .Rs2(Rs2), .S1(S1), .S2(S2),
    .wb_enable(wb_enable), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_func(out_func), .out_a(out_a), .out_b(out_b),
    .out_imm(out_imm), .out_rd(out_rd), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural register values and in-flight destinations.
  logic [31:0] mregs [32];
  logic [31:0] mbusy;

  // Environment register file: one-cycle read latency, read-before-write.
  logic [31:0] rf [32];
  logic        rf_load;
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 32; i++) rf[i] <= mregs[i];
    end else if (wb_enable && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
    S1 <= rf[Rs1];
    S2 <= rf[Rs2];
  end

  // Current-instruction view of the model.
  bit          cu1, cu2;
  logic [4:0]  cs1, cs2, cd;
  logic [31:0] exp_ins, exp_pc, exp_a, exp_b;
  logic [31:0] obs_a, obs_imm;
  logic [4:0]  obs_rd;
  int          last_cycles;

  function automatic void decode(input logic [31:0] ins, output bit u1, output bit u2,
                                 output logic [4:0] s1, output logic [4:0] s2,
                                 output logic [4:0] d);
    logic [5:0] op;
    op = ins[31:26];
    s1 = ins[25:21];
    s2 = ins[20:16];
    u1 = !(op == 6'h02 || op == 6'h03);
    u2 = (op == 6'h00) || (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
    if (op == 6'h00)                                   d = ins[15:11];
    else if (op == 6'h03 || op == 6'h13)               d = 5'd31;
    else if (u2 || op == 6'h04 || op == 6'h05 ||
             op == 6'h12 || op == 6'h02)               d = 5'd0;
    else                                               d = ins[20:16];
  endfunction

  function automatic logic [4:0] blocker();
    if (cu1 && cs1 != 5'd0 && mbusy[cs1]) return cs1;
    if (cu2 && cs2 != 5'd0 && mbusy[cs2]) return cs2;
    if (cd != 5'd0 && mbusy[cd]) return cd;
    return 5'd0;
  endfunction

  task automatic check_bundle(input string p);
    logic signed [31:0] simm;
    logic [5:0] op;
    op = exp_ins[31:26];
    if (op == 6'h02 || op == 6'h03) simm = 32'($signed(exp_ins[25:0]));
    else                            simm = 32'($signed(exp_ins[15:0]));
    check({p, "_opcode"}, out_opcode, op);
    check({p, "_func"},   out_func, (op == 6'h00) ? exp_ins[10:0] : 11'd0);
    check({p, "_a"},      out_a, exp_a);
    check({p, "_b"},      out_b, exp_b);
    check({p, "_imm"},    out_imm, simm);
    check({p, "_rd"},     out_rd, cd);
    check({p, "_pc"},     out_pc, exp_pc);
  endtask

  task automatic wb_model(input logic [4:0] r, input logic [31:0] d);
    wb_enable = 1'b1;
    wb_rd     = r;
    wb_data   = d;
    if (r != 5'd0) begin
      mregs[r] = d;
      mbusy[r] = 1'b0;
    end
  endtask

  // One instruction through the stage. idle < 0 picks random stall gaps;
  // use_dwb forces the blocking writeback data; rand_wb adds extra traffic.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] pc, input int idle,
                           input bit use_dwb, input logic [31:0] dwb, input int hold,
                           input bit rand_wb);
    int  waited, iter, idle_left;
    bit  done;
    logic [4:0] blk, w;
    decode(ins, cu1, cu2, cs1, cs2, cd);
    exp_ins = ins;
    exp_pc  = pc;
    waited  = 0;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = $urandom;
    in_pc    = $urandom;
    idle_left = (idle < 0) ? $urandom_range(0, 2) : idle;
    done = 1'b0;
    iter = 0;
    while (!done && iter < 40) begin
      check("stall_no_valid", out_valid, 0);
      check("stall_no_ready", in_ready, 0);
      check("rs1_drive", Rs1, cu1 ? cs1 : 5'd0);
      check("rs2_drive", Rs2, cu2 ? cs2 : 5'd0);
      wb_enable = 1'b0;
      blk = blocker();
      if (blk != 5'd0) begin
        if (idle_left > 0) begin
          idle_left--;
        end else begin
          wb_model(blk, use_dwb ? dwb : $urandom);
          idle_left = (idle < 0) ? $urandom_range(0, 2) : idle;
          done = (blocker() == 5'd0);
        end
      end else begin
        if (rand_wb && $urandom_range(0, 1) == 1) begin
          w = 5'($urandom_range(0, 31));
          wb_model(w, $urandom);
        end
        done = 1'b1;
      end
      if (done) begin
        exp_a = cu1 ? mregs[cs1] : 32'd0;
        exp_b = cu2 ? mregs[cs2] : 32'd0;
        if (cd != 5'd0) mbusy[cd] = 1'b1;
      end
      @(negedge clk);
      wb_enable = 1'b0;
      iter++;
    end
    last_cycles = iter;
    check("stall_bound", done, 1);
    check("capt_no_valid", out_valid, 0);
    @(negedge clk);
    check("valid_up", out_valid, 1);
    check("valid_no_ready", in_ready, 0);
    check_bundle("bundle");
    check("busy", dut.busy, mbusy);
    obs_a   = out_a;
    obs_imm = out_imm;
    obs_rd  = out_rd;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      if (rand_wb && $urandom_range(0, 1) == 1) begin
        w = 5'($urandom_range(1, 31));
        if (mbusy[w]) wb_model(w, $urandom);
      end
      @(negedge clk);
      wb_enable = 1'b0;
      check("hold_valid", out_valid, 1);
      check("hold_no_ready", in_ready, 0);
      check_bundle("hold");
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_idle", in_ready, 1);
    check("release_no_valid", out_valid, 0);
    check("release_busy", dut.busy, mbusy);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  ops [12];
    logic [31:0] w, sel;
    ops = '{6'h00, 6'h28, 6'h29, 6'h2B, 6'h04, 6'h05, 6'h12, 6'h02, 6'h03, 6'h13, 6'h08, 6'h23};
    w   = $urandom;
    sel = $urandom;
    if (sel[3:0] == 4'd0) return w;
    return {ops[$urandom_range(0, 11)], w[25:0]};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_instr = '0; in_pc = '0;
    wb_enable = 1'b0; wb_rd = '0; wb_data = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = $urandom;
    mregs[0] = 32'd0;
    mregs[1] = 32'd5;
    mregs[2] = 32'd7;
    mbusy = '0;
    rf_load = 1'b1;
    repeat (3) @(negedge clk);
    rf_load = 1'b0;
    reset = 1'b0;

    // Reset state.
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", dut.busy, 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_rd", out_rd, 0);

    // ADD r3,r1,r2: no hazard, single CHECK cycle.
    run_instr({6'h00, 5'd1, 5'd2, 5'd3, 11'h020}, 32'h0000_0100, 0, 0, 0, 0, 0);
    check("add_nostall", last_cycles, 1);
    check("add_a", obs_a, 5);
    check("add_rd", obs_rd, 3);

    // ADDI r4,r3,#-1: stalls on r3 until writeback of 12, forwarded.
    run_instr({6'h08, 5'd3, 5'd4, 16'hFFFF}, 32'h0000_0104, 2, 1, 32'd12, 0, 0);
    check("addi_stall_len", last_cycles, 3);
    check("addi_fwd_a", obs_a, 12);
    check("addi_imm", obs_imm, 32'hFFFF_FFFF);
    check("addi_busy3", dut.busy[3], 0);
    check("addi_busy4", dut.busy[4], 1);

    // WAW: two LW r6,0(r0); the second waits for r6 writeback.
    run_instr({6'h23, 5'd0, 5'd6, 16'h0000}, 32'h0000_0108, 0, 0, 0, 0, 0);
    run_instr({6'h23, 5'd0, 5'd6, 16'h0000}, 32'h0000_010C, 3, 0, 0, 0, 0);
    check("waw_stall_len", last_cycles, 4);
    check("waw_busy6", dut.busy[6], 1);

    // Fill busy[1..30], then JAL must not stall; hold out_ready low 5 cycles.
    for (int i = 1; i <= 30; i++)
      if (!mbusy[i]) run_instr({6'h08, 5'd0, 5'(i), 16'(i)}, 32'h200 + 32'(i * 4), 0, 0, 0, 0, 0);
    run_instr({6'h03, 26'h3FF_FFFC}, 32'h0000_0300, 0, 0, 0, 5, 0);
    check("jal_nostall", last_cycles, 1);
    check("jal_rd", obs_rd, 31);
    check("jal_imm", obs_imm, 32'hFFFF_FFFC);

    // Writeback to r0 changes nothing.
    wb_enable = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
    @(negedge clk);
    wb_enable = 1'b0;
    check("wb_r0_busy", dut.busy, 32'hFFFF_FFFE);

    // Drain the scoreboard.
    for (int r = 1; r < 32; r++) begin
      if (mbusy[r]) begin
        wb_model(5'(r), $urandom);
        @(negedge clk);
        wb_enable = 1'b0;
      end
    end
    check("drain_busy", dut.busy, 0);

    // Asynchronous reset while stalled in CHECK with busy[9] set.
    run_instr({6'h23, 5'd0, 5'd9, 16'h0010}, 32'h0000_0400, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    in_instr = {6'h00, 5'd9, 5'd9, 5'd10, 11'h020};
    in_pc    = 32'h0000_0404;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_stalled", in_ready, 0);
    check("pre_rst_busy9", dut.busy[9], 1);
    #2 reset = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", dut.busy, 0);
    check("arst_out_pc", out_pc, 0);
    check("arst_out_rd", out_rd, 0);
    check("arst_out_imm", out_imm, 0);
    @(negedge clk);
    reset = 1'b0;
    mbusy = '0;

    // Randomized instruction stream.
    for (int n = 0; n < 250; n++)
      run_instr(rand_instr(), $urandom, -1, 0, 0, $urandom_range(0, 3), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
